// File: rtl/stream_source.sv
// Self-contained valid/ready stream transmitter.
// Emits a programmable run of ramp, down-ramp, LFSR or constant samples with optional idle gaps.
module stream_source #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned GAP_W  = 8,
    parameter int unsigned STEP   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  count,
    input  logic [GAP_W-1:0]  gap,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count
);

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_DOWN  = 2'd3;

    localparam logic [63:0]       LFSR_POLY64 = 64'hD800_0000_0000_0000;
    localparam logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(LFSR_POLY64);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               beat;
    logic [CNT_W-1:0]   sent_inc;

    // Next sample in the selected pattern; only called on an accepted beat.
    function automatic logic [DATA_W-1:0] advance(input logic [1:0] m, input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] nxt;
        case (m)
            MODE_RAMP:  nxt = cur + DATA_W'(STEP);
            MODE_LFSR:  nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
            MODE_DOWN:  nxt = cur - DATA_W'(STEP);
            MODE_CONST: nxt = cur;
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

    assign beat     = valid_q & out_ready;
    assign sent_inc = sent_q + CNT_W'(1);

    // Next-state and registered-output computation for the run controller.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sent_d    = sent_q;
        gap_cnt_d = gap_cnt_q;
        mode_d    = mode_q;
        count_d   = count_q;
        gap_d     = gap_q;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    sent_d = '0;
                    if (count != '0) begin
                        mode_d  = mode;
                        count_d = count;
                        gap_d   = gap;
                        // An all-zero LFSR would lock up, so it is nudged to 1.
                        data_d  = (mode == MODE_LFSR && seed == '0) ? DATA_W'(1) : seed;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_SEND;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                // Without a beat everything holds; stop waits for the beat boundary.
                if (beat) begin
                    sent_d = sent_inc;
                    data_d = advance(mode_q, data_q);
                    if (sent_inc == count_q || stop) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (gap_q != '0) begin
                        valid_d   = 1'b0;
                        gap_cnt_d = gap_q;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                valid_d   = 1'b0;
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (stop) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the run immediately with no done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sent_q    <= '0;
            gap_cnt_q <= '0;
            mode_q    <= MODE_RAMP;
            count_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sent_q    <= sent_d;
            gap_cnt_q <= gap_cnt_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = sent_q;

endmodule
